// File: rtl/ask4_defs.sv
// ---------------------------------------------------------------------------
// ask4_defs
//   Shared definitions for the 4-ASK symbol source and the downstream BER
//   checker: sample format, Gray symbol codes, default inner level, the
//   LFSR step function and the symbol -> level map.
//   No ports (package).
// ---------------------------------------------------------------------------
package ask4_defs;

    localparam int SAMPLE_W        = 18;     // signed 1s17 samples
    localparam int FRAC_BITS       = 17;
    localparam int LFSR_W          = 22;
    localparam int DEFAULT_LEVEL_A = 21845;  // ~1/6 in 1s17

    // Largest positive 1s17 value, used as the impulse amplitude.
    localparam logic [SAMPLE_W-1:0] FULL_SCALE = SAMPLE_W'((1 << FRAC_BITS) - 1);

    // Gray-coded 4-ASK symbols: adjacent levels differ in one bit.
    typedef enum logic [1:0] {
        SYM_M3 = 2'b00,
        SYM_M1 = 2'b01,
        SYM_P1 = 2'b11,
        SYM_P3 = 2'b10
    } sym_t;

    // One step of the x^22 + x^21 + 1 Fibonacci LFSR (shift left, feedback in).
    function automatic logic [LFSR_W-1:0] lfsr22_step(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], s[21] ^ s[20]};
    endfunction

    // Gray symbol to signed level. The outer level is 3*a truncated to the
    // sample width; range is guarded at elaboration by the instantiating top.
    function automatic logic [SAMPLE_W-1:0] sym_to_level(input logic [1:0]          sym,
                                                         input logic [SAMPLE_W-1:0] level_a);
        logic [SAMPLE_W-1:0] inner;
        logic [SAMPLE_W-1:0] outer;
        logic [SAMPLE_W-1:0] lvl;
        inner = level_a;
        outer = SAMPLE_W'({2'b00, level_a} * 20'd3);
        case (sym_t'(sym))
            SYM_M3:  lvl = -outer;
            SYM_M1:  lvl = -inner;
            SYM_P1:  lvl = inner;
            SYM_P3:  lvl = outer;
            default: lvl = '0;
        endcase
        return lvl;
    endfunction

endpackage

// File: rtl/lfsr22.sv
// ---------------------------------------------------------------------------
// lfsr22
//   22-bit maximal-length LFSR (x^22 + x^21 + 1). Shared with the BER checker
//   so both ends generate the identical PRBS.
// Ports:
//   clk    in   1   clock
//   reset  in   1   synchronous, active-high; loads seed (0 is replaced by 1)
//   adv    in   1   advance one step this edge
//   seed   in   22  reset value
//   state  out  22  current register contents
// ---------------------------------------------------------------------------
module lfsr22
    import ask4_defs::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              adv,
    input  logic [LFSR_W-1:0] seed,
    output logic [LFSR_W-1:0] state
);

    logic [LFSR_W-1:0] state_reg;
    logic [LFSR_W-1:0] seed_safe;

    // All-zero is the lock-up state of an XOR LFSR, so never load it.
    assign seed_safe = (seed == '0) ? LFSR_W'(1) : seed;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= seed_safe;
        end else if (adv) begin
            state_reg <= lfsr22_step(state_reg);
        end
    end

    assign state = state_reg;

endmodule

// File: rtl/ask4_symbol_source.sv
// ---------------------------------------------------------------------------
// ask4_symbol_source
//   Stimulus stage for the 31-tap pulse-shaping FIR. Produces a PRBS 2-bit
//   symbol stream, Gray-maps it to 4-ASK levels (1s17) and zero-stuffs it up
//   to the sample rate. A one-cycle strobe marks samples carrying a symbol.
//
//   Build option IMPULSE_TEST_EN: replaces the PRBS map with a full-scale
//   impulse every IMPULSE_PERIOD symbol slots (slot 0 after reset) for FIR
//   impulse-response capture. The LFSR keeps advancing in either build.
//
// Ports:
//   clk         in   1   sample clock
//   reset       in   1   synchronous, active-high
//   enable      in   1   advance enable; low holds phase and LFSR
//   x_out       out  18  signed 1s17 sample to FIR x_in (registered)
//   sym_strobe  out  1   high for the cycle x_out carries a symbol
//   sym_out     out  2   Gray bits of the current symbol (registered)
// ---------------------------------------------------------------------------
module ask4_symbol_source
    import ask4_defs::*;
#(
    parameter int                UPSAMPLE       = 4,
    parameter int                LEVEL_A        = DEFAULT_LEVEL_A,
    parameter logic [LFSR_W-1:0] LFSR_SEED      = 22'h000001,
    parameter int                IMPULSE_PERIOD = 16
)
(
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    output logic [SAMPLE_W-1:0] x_out,
    output logic                sym_strobe,
    output logic [1:0]          sym_out
);

    // ---------------------------------------------------------------------
    // Elaboration checks
    // ---------------------------------------------------------------------
    if (UPSAMPLE < 2 || UPSAMPLE > 16) begin : g_bad_upsample
        $error("ask4_symbol_source: UPSAMPLE must be in 2..16");
    end
    if (LEVEL_A < 0 || 3 * LEVEL_A > 131071) begin : g_bad_level
        $error("ask4_symbol_source: 3*LEVEL_A must fit in 0..131071");
    end
    if (IMPULSE_PERIOD < 1) begin : g_bad_period
        $error("ask4_symbol_source: IMPULSE_PERIOD must be at least 1");
    end

    localparam int                  PHASE_W     = $clog2(UPSAMPLE);
    localparam logic [PHASE_W-1:0]  PHASE_LAST  = PHASE_W'(UPSAMPLE - 1);
    localparam logic [SAMPLE_W-1:0] LEVEL_A_VEC = SAMPLE_W'(LEVEL_A);

    logic [PHASE_W-1:0]  phase_reg;
    logic [PHASE_W-1:0]  phase_next;
    logic                sym_cycle;
    logic [LFSR_W-1:0]   lfsr_state;
    logic [1:0]          sym_value;
    logic [SAMPLE_W-1:0] level;

    logic [SAMPLE_W-1:0] x_reg;
    logic [SAMPLE_W-1:0] x_next;
    logic                strobe_reg;
    logic                strobe_next;
    logic [1:0]          sym_reg;
    logic [1:0]          sym_next;

    // A symbol is launched on the enabled cycle where the phase is zero.
    assign sym_cycle = enable && (phase_reg == '0);

    // ---------------------------------------------------------------------
    // Phase counter
    // ---------------------------------------------------------------------
    always_comb begin
        phase_next = phase_reg + PHASE_W'(1);
        if (phase_reg == PHASE_LAST) begin
            phase_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_reg <= '0;
        end else if (enable) begin
            phase_reg <= phase_next;
        end
    end

    // ---------------------------------------------------------------------
    // PRBS source
    // ---------------------------------------------------------------------
    lfsr22 u_lfsr (
        .clk   (clk),
        .reset (reset),
        .adv   (sym_cycle),
        .seed  (LFSR_SEED),
        .state (lfsr_state)
    );

    // The LFSR must never lock up at zero; the seed guard makes that
    // unreachable, so a hit here means corrupted state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (lfsr_state != '0);
        end
    end

`ifdef IMPULSE_TEST_EN
    // ---------------------------------------------------------------------
    // Impulse mode: slot counter over symbol slots, impulse on slot 0
    // ---------------------------------------------------------------------
    localparam int                 SLOT_W    = (IMPULSE_PERIOD > 1) ? $clog2(IMPULSE_PERIOD) : 1;
    localparam logic [SLOT_W-1:0]  SLOT_LAST = SLOT_W'(IMPULSE_PERIOD - 1);

    logic [SLOT_W-1:0] slot_reg;
    logic [SLOT_W-1:0] slot_next;
    logic              impulse_slot;

    always_comb begin
        slot_next = slot_reg + SLOT_W'(1);
        if (slot_reg == SLOT_LAST) begin
            slot_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            slot_reg <= '0;
        end else if (sym_cycle) begin
            slot_reg <= slot_next;
        end
    end

    assign impulse_slot = (slot_reg == '0);
    assign sym_value    = impulse_slot ? SYM_P3 : SYM_M3;
    assign level        = impulse_slot ? FULL_SCALE : '0;
`else
    // Symbol bits are the low two bits of the LFSR after this cycle's step,
    // taken combinationally so the symbol appears one edge after phase==0.
    assign sym_value = {lfsr_state[0], lfsr_state[21] ^ lfsr_state[20]};
    assign level     = sym_to_level(sym_value, LEVEL_A_VEC);
`endif

    // ---------------------------------------------------------------------
    // Output registers: zero-stuff between symbols and during stalls
    // ---------------------------------------------------------------------
    always_comb begin
        x_next      = '0;
        strobe_next = 1'b0;
        sym_next    = sym_reg;
        if (sym_cycle) begin
            x_next      = level;
            strobe_next = 1'b1;
            sym_next    = sym_value;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x_reg      <= '0;
            strobe_reg <= 1'b0;
            sym_reg    <= 2'b00;
        end else begin
            x_reg      <= x_next;
            strobe_reg <= strobe_next;
            sym_reg    <= sym_next;
        end
    end

    assign x_out      = x_reg;
    assign sym_strobe = strobe_reg;
    assign sym_out    = sym_reg;

endmodule

// File: tb/tb_ask4_symbol_source.sv
// ---------------------------------------------------------------------------
// tb_ask4_symbol_source
//   Self-checking bench for ask4_symbol_source. The reference is a list of
//   symbols precomputed from the seed plus a count of enabled cycles since
//   reset: symbol k appears on the enabled cycle numbered k*UPSAMPLE.
// ---------------------------------------------------------------------------
module tb_ask4_symbol_source;

    localparam int UPS    = 4;
    localparam int A      = 21845;
    localparam int PERIOD = 16;
    localparam int NSEQ   = 4096;

    logic        clk    = 1'b0;
    logic        reset  = 1'b1;
    logic        enable = 1'b0;
    logic [17:0] x_out;
    logic        sym_strobe;
    logic [1:0]  sym_out;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    ask4_symbol_source #(
        .UPSAMPLE       (UPS),
        .LEVEL_A        (A),
        .LFSR_SEED      (22'h000001),
        .IMPULSE_PERIOD (PERIOD)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .x_out      (x_out),
        .sym_strobe (sym_strobe),
        .sym_out    (sym_out)
    );

    // ---------------------------------------------------------------------
    // Reference model
    // ---------------------------------------------------------------------
    int   seq_sym [NSEQ];
    int   en_cnt      = 0;
    int   exp_x       = 0;
    int   exp_strobe  = 0;
    int   exp_sym     = 0;
    bit   model_valid = 1'b0;

    function automatic int level_of(input int s);
        case (s)
            0:       return -3 * A;
            1:       return -A;
            3:       return A;
            2:       return 3 * A;
            default: return 0;
        endcase
    endfunction

    // Symbol k after reset = low two bits of the LFSR after k+1 steps.
    task automatic build_sequence();
        longint l;
        l = 1;
        for (int k = 0; k < NSEQ; k++) begin
            l = ((l * 2) % (longint'(1) << 22)) + (((l >> 21) ^ (l >> 20)) & 1);
            seq_sym[k] = int'(l % 4);
        end
    endtask

    always @(posedge clk) begin
        int k;
        model_valid = 1'b1;
        if (reset) begin
            en_cnt     = 0;
            exp_x      = 0;
            exp_strobe = 0;
            exp_sym    = 0;
        end else if (enable) begin
            if (en_cnt % UPS == 0) begin
                k = en_cnt / UPS;
`ifdef IMPULSE_TEST_EN
                exp_x   = (k % PERIOD == 0) ? 131071 : 0;
                exp_sym = (k % PERIOD == 0) ? 2 : 0;
`else
                exp_sym = seq_sym[k % NSEQ];
                exp_x   = level_of(exp_sym);
`endif
                exp_strobe = 1;
            end else begin
                exp_x      = 0;
                exp_strobe = 0;
            end
            en_cnt++;
        end else begin
            exp_x      = 0;
            exp_strobe = 0;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------------
    // Per-cycle compare against the model, away from the active edge
    // ---------------------------------------------------------------------
    always @(negedge clk) begin
        if (model_valid) begin
            check("x_out", int'($signed(x_out)), exp_x);
            check("sym_strobe", int'(sym_strobe), exp_strobe);
            check("sym_out", int'(sym_out), exp_sym);
            if (sym_strobe) begin
                $display("[TB] t=%0t symbol sym_out=%b x_out=%0d", $time, sym_out, $signed(x_out));
            end
        end
    end

    // ---------------------------------------------------------------------
    // Directed helpers
    // ---------------------------------------------------------------------
    task automatic wait_strobe(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (sym_strobe) begin
                ok = 1'b1;
                break;
            end
        end
        check({name, "_strobe_seen"}, int'(ok), 1);
    endtask

    task automatic measure_gap(output int gap);
        gap = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            gap++;
            if (sym_strobe) break;
        end
    endtask

    // ---------------------------------------------------------------------
    // Stimulus
    // ---------------------------------------------------------------------
    initial begin
        int gap;
        build_sequence();

        // Pin the model against hand-derived values from seed 1:
        // steps give 0b10, 0b100, 0b1000 -> symbols 10, 00, 00.
        check("model_seq0", seq_sym[0], 2);
        check("model_seq1", seq_sym[1], 0);
        check("model_seq2", seq_sym[2], 0);
        check("model_level_p3", level_of(seq_sym[0]), 65535);

        // Reset held for 3 clocks with enable high.
        reset  = 1'b1;
        enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset_x_out", int'($signed(x_out)), 0);
            check("reset_strobe", int'(sym_strobe), 0);
            check("reset_sym_out", int'(sym_out), 0);
        end
        reset = 1'b0;

        // First symbols after release.
        wait_strobe("first_sym");
        check("first_sym_x", int'($signed(x_out)), (`ifdef IMPULSE_TEST_EN 131071 `else 65535 `endif));
        check("first_sym_bits", int'(sym_out), 2);
        wait_strobe("second_sym");
        check("second_sym_x", int'($signed(x_out)), (`ifdef IMPULSE_TEST_EN 0 `else -65535 `endif));
        check("second_sym_bits", int'(sym_out), 0);
        wait_strobe("third_sym");
        check("third_sym_x", int'($signed(x_out)), (`ifdef IMPULSE_TEST_EN 0 `else -65535 `endif));

        // Strobe spacing equals the upsampling factor.
        measure_gap(gap);
        check("strobe_gap", gap, UPS);

        // Stall for 5 clocks mid-symbol; output must be zero throughout.
        @(negedge clk);
        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_x_out", int'($signed(x_out)), 0);
            check("stall_strobe", int'(sym_strobe), 0);
        end
        enable = 1'b1;
        wait_strobe("post_stall");

        // Reset at phase 2: the next symbol restarts from the seed.
        wait_strobe("pre_reset");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        wait_strobe("post_reset");
        check("post_reset_x", int'($signed(x_out)), (`ifdef IMPULSE_TEST_EN 131071 `else 65535 `endif));
        check("post_reset_bits", int'(sym_out), 2);

        // Randomized enable pattern with occasional resets.
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            enable = ($urandom_range(0, 7) != 0);
            reset  = ($urandom_range(0, 399) == 0);
        end
        reset  = 1'b0;
        enable = 1'b1;
        repeat (8) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
